// File: rtl/line_column_buffer_if.sv
// Pixel-in / column-out bundle for line_column_buffer.
// The master drives pixels and receives columns; the slave is the buffer itself.
interface line_column_buffer_if #(
  parameter int N     = 8,
  parameter int WIDTH = 640,
  parameter int ROWS  = 5
);
  localparam int XW = $clog2(WIDTH);

  logic                 ivalid;
  logic                 isof;
  logic [N-1:0]         idata;
  logic                 ovalid;
  logic [ROWS*N-1:0]    ocolumn;
  logic [XW-1:0]        ox;
  logic                 oeol;
  logic                 ofull;

  modport master (
    output ivalid, isof, idata,
    input  ovalid, ocolumn, ox, oeol, ofull
  );

  modport slave (
    input  ivalid, isof, idata,
    output ovalid, ocolumn, ox, oeol, ofull
  );
endinterface

// File: rtl/line_column_buffer.sv
// Keeps the last ROWS-1 image lines and emits one ROWS-tall column per accepted pixel,
// masking rows that do not yet hold data from the current frame.
module line_column_buffer #(
  parameter int N     = 8,
  parameter int WIDTH = 640,
  parameter int ROWS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  line_column_buffer_if.slave   bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int FW = $clog2(ROWS);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [FW-1:0] FMAX = FW'(ROWS - 1);

  logic [XW-1:0]      r_xcnt;
  logic [FW-1:0]      r_fill;
  logic               w_accept;
  logic [XW-1:0]      w_x;
  logic [FW-1:0]      w_fill;
  logic [N-1:0]       w_rd [ROWS-1];
  logic [ROWS*N-1:0]  w_col;

  // A start-of-frame pixel overrides the counters so it always lands at x=0 of line 0.
  assign w_accept = bus.ivalid;
  assign w_x      = bus.isof ? '0 : r_xcnt;
  assign w_fill   = bus.isof ? '0 : r_fill;

  // Line k reads its old entry and takes line k-1's old entry in the same cycle,
  // so each line memory shifts the column up by one line.
  for (genvar k = 0; k < ROWS - 1; k++) begin : g_line
    logic [N-1:0] r_mem [WIDTH];
    logic [N-1:0] w_wr;

    if (k == 0) begin : g_first
      assign w_wr = bus.idata;
    end else begin : g_chain
      assign w_wr = w_rd[k-1];
    end

    assign w_rd[k] = r_mem[w_x];

    always_ff @(posedge clk) begin
      if (w_accept) r_mem[w_x] <= w_wr;
    end
  end

  // Row r (0 = oldest) comes from line memory ROWS-2-r and needs fill >= ROWS-1-r.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == ROWS - 1) begin : g_cur
      assign w_col[r*N +: N] = bus.idata;
    end else begin : g_old
      localparam logic [FW-1:0] NEED = FW'(ROWS - 1 - r);
      assign w_col[r*N +: N] = (w_fill >= NEED) ? w_rd[ROWS-2-r] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xcnt <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      if (w_x == XMAX) begin
        r_xcnt <= '0;
        r_fill <= (w_fill == FMAX) ? w_fill : w_fill + 1'b1;
      end else begin
        r_xcnt <= w_x + 1'b1;
        r_fill <= w_fill;
      end
    end
  end

  // Column data and flags only update on accepted pixels; during gaps they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ovalid  <= 1'b0;
      bus.ocolumn <= '0;
      bus.ox      <= '0;
      bus.oeol    <= 1'b0;
      bus.ofull   <= 1'b0;
    end else begin
      bus.ovalid <= w_accept;
      if (w_accept) begin
        bus.ocolumn <= w_col;
        bus.ox      <= w_x;
        bus.oeol    <= (w_x == XMAX);
        bus.ofull   <= (w_fill == FMAX);
      end
    end
  end
endmodule

// File: tb/tb_line_column_buffer.sv
// Directed bench for line_column_buffer: a small 4x3 instance for framing, gaps,
// resets and masking, plus a 640-wide 2-row instance for full-length lines.
module tb_line_column_buffer;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  line_column_buffer_if #(.N(8), .WIDTH(4), .ROWS(3)) bus1 ();
  line_column_buffer_if #(.N(8), .WIDTH(640), .ROWS(2)) bus2 ();

  line_column_buffer #(.N(8), .WIDTH(4), .ROWS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  line_column_buffer #(.N(8), .WIDTH(640), .ROWS(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2)
  );

  // Inputs change on the falling edge; the caller inspects outputs at the following falling edge.
  task automatic step1(input logic v, input logic s, input logic [7:0] d);
    bus1.ivalid = v;
    bus1.isof   = s;
    bus1.idata  = d;
    @(negedge clk);
  endtask

  task automatic step2(input logic v, input logic s, input logic [7:0] d);
    bus2.ivalid = v;
    bus2.isof   = s;
    bus2.idata  = d;
    @(negedge clk);
  endtask

  // Packed layout used for small-instance checks: {ovalid, ocolumn[23:0], ox[1:0], oeol, ofull}.
  function automatic logic [28:0] expect1(input logic [7:0] r2, input logic [7:0] r1,
                                          input logic [7:0] r0, input int x, input logic full);
    return {1'b1, r2, r1, r0, 2'(x), (x == 3), full};
  endfunction

  task automatic test_reset();
    logic [28:0] got;
    logic [27:0] got2;
    got  = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
    got2 = {bus2.ovalid, bus2.ocolumn, bus2.ox, bus2.ofull};
    tests++;
    if (got !== 29'd0) begin
      fails++;
      $display("[TB] FAIL reset_small: got %h expected %h", got, 29'd0);
    end
    tests++;
    if (got2 !== 28'd0 || bus2.oeol !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_wide: got %h eol %b expected 0", got2, bus2.oeol);
    end
  endtask

  task automatic test_continuous();
    logic [28:0] got, exp;
    int x, y;
    for (int p = 1; p <= 12; p++) begin
      step1(1'b1, 1'(p == 1), 8'(p));
      x   = (p - 1) % 4;
      y   = (p - 1) / 4;
      exp = expect1(8'(p), (y >= 1) ? 8'(p - 4) : 8'h00, (y >= 2) ? 8'(p - 8) : 8'h00,
                    x, (y >= 2));
      got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL continuous p=%0d: got %h expected %h", p, got, exp);
      end
    end
  endtask

  task automatic test_second_frame();
    logic [28:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      step1(1'b1, 1'(i == 0), 8'(101 + i));
      exp = expect1(8'(101 + i), 8'h00, 8'h00, i, 1'b0);
      got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL second_frame i=%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_gaps();
    logic [28:0] got, exp;
    logic [27:0] gotg, expg;
    int x, y;
    for (int p = 1; p <= 12; p++) begin
      step1(1'b1, 1'(p == 1), 8'(p));
      x   = (p - 1) % 4;
      y   = (p - 1) / 4;
      exp = expect1(8'(p), (y >= 1) ? 8'(p - 4) : 8'h00, (y >= 2) ? 8'(p - 8) : 8'h00,
                    x, (y >= 2));
      got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL gaps_pixel p=%0d: got %h expected %h", p, got, exp);
      end
      step1(1'b0, 1'b1, 8'hAA);
      expg = {1'b0, exp[27:1]};
      gotg = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol};
      tests++;
      if (gotg !== expg) begin
        fails++;
        $display("[TB] FAIL gaps_hold p=%0d: got %h expected %h", p, gotg, expg);
      end
    end
  endtask

  task automatic test_sof_midline();
    logic [28:0] got, exp [5];
    logic [7:0]  vals [7];
    logic        sofs [7];
    vals = '{8'd1, 8'd2, 8'd50, 8'd51, 8'd52, 8'd53, 8'd60};
    sofs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp[0] = expect1(8'd50, 8'd0,  8'd0, 0, 1'b0);
    exp[1] = expect1(8'd51, 8'd0,  8'd0, 1, 1'b0);
    exp[2] = expect1(8'd52, 8'd0,  8'd0, 2, 1'b0);
    exp[3] = expect1(8'd53, 8'd0,  8'd0, 3, 1'b0);
    exp[4] = expect1(8'd60, 8'd50, 8'd0, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step1(1'b1, sofs[i], vals[i]);
      if (i >= 2) begin
        got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
        tests++;
        if (got !== exp[i-2]) begin
          fails++;
          $display("[TB] FAIL sof_midline i=%0d: got %h expected %h", i, got, exp[i-2]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [28:0] got, exp;
    for (int p = 1; p <= 10; p++) step1(1'b1, 1'(p == 1), 8'(p));
    got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
    exp = expect1(8'd10, 8'd6, 8'd2, 1, 1'b1);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL pre_reset: got %h expected %h", got, exp);
    end
    bus1.ivalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
    tests++;
    if (got !== 29'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: got %h expected %h", got, 29'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step1(1'b1, 1'b0, 8'd77);
    got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
    exp = expect1(8'd77, 8'd0, 8'd0, 0, 1'b0);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL after_reset0: got %h expected %h", got, exp);
    end
    step1(1'b1, 1'b0, 8'd78);
    got = {bus1.ovalid, bus1.ocolumn, bus1.ox, bus1.oeol, bus1.ofull};
    exp = expect1(8'd78, 8'd0, 8'd0, 1, 1'b0);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL after_reset1: got %h expected %h", got, exp);
    end
    bus1.ivalid = 1'b0;
  endtask

  task automatic test_rows2_wide();
    logic [27:0] got, exp;
    logic [7:0]  cur, prv;
    int x, y, eols;
    eols = 0;
    for (int i = 0; i < 3 * 640; i++) begin
      x   = i % 640;
      y   = i / 640;
      cur = 8'(x + 7 * y);
      prv = (y >= 1) ? 8'(x + 7 * (y - 1)) : 8'h00;
      step2(1'b1, 1'(i == 0), cur);
      exp = {1'b1, cur, prv, 10'(x), (y >= 1)};
      got = {bus2.ovalid, bus2.ocolumn, bus2.ox, bus2.ofull};
      if (bus2.oeol === 1'b1) eols++;
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL rows2 i=%0d: got %h expected %h", i, got, exp);
      end
    end
    step2(1'b0, 1'b0, 8'h00);
    if (bus2.oeol === 1'b1 && bus2.ovalid === 1'b1) eols++;
    tests++;
    if (eols !== 3) begin
      fails++;
      $display("[TB] FAIL rows2_eol_count: got %0d expected %0d", eols, 3);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    bus1.ivalid = 1'b0;
    bus1.isof   = 1'b0;
    bus1.idata  = 8'h00;
    bus2.ivalid = 1'b0;
    bus2.isof   = 1'b0;
    bus2.idata  = 8'h00;
    #12;
    test_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    test_continuous();
    test_second_frame();
    test_gaps();
    test_sof_midline();
    test_async_reset();
    test_rows2_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
